// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port (instruction/data) arbiter onto a single memory bus, alternating on contention
module mem_bus_arbiter #(
    parameter int A_WIDTH = 32
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [A_WIDTH-1:0] i_a,
    input  logic [31:0]        i_dout,
    input  logic [3:0]         i_wen,
    input  logic [1:0]         i_size,
    input  logic               i_rw,
    input  logic               i_strobe,
    output logic [31:0]        i_din,
    output logic               i_ready,
    input  logic [A_WIDTH-1:0] d_a,
    input  logic [31:0]        d_dout,
    input  logic [3:0]         d_wen,
    input  logic [1:0]         d_size,
    input  logic               d_rw,
    input  logic               d_strobe,
    output logic [31:0]        d_din,
    output logic               d_ready,
    output logic [A_WIDTH-1:0] m_a,
    output logic [31:0]        m_din,
    output logic [3:0]         m_wen,
    output logic [1:0]         m_size,
    output logic               m_rw,
    output logic               m_strobe,
    input  logic [31:0]        m_dout,
    input  logic               m_ready,
    output logic [1:0]         grant
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, next;
    logic   last_d;
    logic   pick_d, pick_i;
    // On contention the side not served last wins; last_d=0 means instruction was last
    assign pick_d = d_strobe & (~i_strobe | ~last_d);
    assign pick_i = i_strobe & ~pick_d;
    always_comb begin
        next = state;
        if (state == IDLE)
            next = pick_d ? SERVE_D : pick_i ? SERVE_I : IDLE;
        else if (m_ready)
            next = IDLE;
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            last_d <= 1'b0;
            m_a    <= '0;
            m_din  <= '0;
            m_wen  <= '0;
            m_size <= '0;
            m_rw   <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && (pick_d || pick_i)) begin
                last_d <= pick_d;
                m_a    <= pick_d ? d_a : i_a;
                m_din  <= pick_d ? d_dout : i_dout;
                m_wen  <= pick_d ? d_wen : i_wen;
                m_size <= pick_d ? d_size : i_size;
                m_rw   <= pick_d ? d_rw : i_rw;
            end
        end
    end
    assign m_strobe = state != IDLE;
    assign grant    = {state == SERVE_D, state == SERVE_I};
    assign i_ready  = m_ready & (state == SERVE_I);
    assign d_ready  = m_ready & (state == SERVE_D);
    assign i_din    = m_dout;
    assign d_din    = m_dout;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against a transaction-level owner model
module tb_mem_bus_arbiter;
    logic        clk = 0;
    logic        clrn = 0;
    logic [31:0] i_a = 0, i_dout = 0, d_a = 0, d_dout = 0, m_dout = 0;
    logic [3:0]  i_wen = 0, d_wen = 0;
    logic [1:0]  i_size = 0, d_size = 0;
    logic        i_rw = 0, d_rw = 0, i_strobe = 0, d_strobe = 0, m_ready = 0;
    logic [31:0] i_din, d_din, m_a, m_din;
    logic [3:0]  m_wen;
    logic [1:0]  m_size, grant;
    logic        i_ready, d_ready, m_rw, m_strobe;
    int checks = 0, errors = 0;
    int owner = 0, last = 1;
    logic [31:0] ea = 0, edout = 0;
    logic [3:0]  ewen = 0;
    logic [1:0]  esize = 0;
    logic        erw = 0;
    mem_bus_arbiter #(.A_WIDTH(32)) dut (
        .clk(clk), .clrn(clrn),
        .i_a(i_a), .i_dout(i_dout), .i_wen(i_wen), .i_size(i_size), .i_rw(i_rw),
        .i_strobe(i_strobe), .i_din(i_din), .i_ready(i_ready),
        .d_a(d_a), .d_dout(d_dout), .d_wen(d_wen), .d_size(d_size), .d_rw(d_rw),
        .d_strobe(d_strobe), .d_din(d_din), .d_ready(d_ready),
        .m_a(m_a), .m_din(m_din), .m_wen(m_wen), .m_size(m_size), .m_rw(m_rw),
        .m_strobe(m_strobe), .m_dout(m_dout), .m_ready(m_ready), .grant(grant)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // Inputs are already applied; check outputs mid-cycle, then advance the model across the edge
    task automatic step();
        #1;
        if (!clrn) begin
            owner = 0; last = 1; ea = 0; edout = 0; ewen = 0; esize = 0; erw = 0;
        end
        check("grant", grant, 32'(owner));
        check("m_strobe", m_strobe, owner != 0);
        check("m_a", m_a, ea);
        check("m_din", m_din, edout);
        check("m_wen", m_wen, ewen);
        check("m_size", m_size, esize);
        check("m_rw", m_rw, erw);
        check("i_ready", i_ready, m_ready && owner == 1);
        check("d_ready", d_ready, m_ready && owner == 2);
        check("i_din", i_din, m_dout);
        check("d_din", d_din, m_dout);
        @(posedge clk);
        if (clrn) begin
            if (owner == 0) begin
                if (i_strobe && d_strobe) owner = (last == 1) ? 2 : 1;
                else owner = d_strobe ? 2 : (i_strobe ? 1 : 0);
                if (owner != 0) last = owner;
                if (owner == 1) begin ea = i_a; edout = i_dout; ewen = i_wen; esize = i_size; erw = i_rw; end
                if (owner == 2) begin ea = d_a; edout = d_dout; ewen = d_wen; esize = d_size; erw = d_rw; end
            end else if (m_ready) owner = 0;
        end
        #1;
    endtask
    initial begin
        logic [1:0] seq [5];
        seq = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        #2;
        step(); step();
        clrn = 1;
        // single data read, memory answers after 3 cycles
        d_strobe = 1; d_a = 32'h8000_0010; d_rw = 0;
        step();
        check("rd_m_a", m_a, 32'h8000_0010);
        for (int k = 0; k < 2; k++) step();
        m_ready = 1; m_dout = 32'hDEAD_BEEF;
        #1;
        check("rd_d_din", d_din, 32'hDEAD_BEEF);
        check("rd_d_ready", d_ready, 1);
        check("rd_i_ready", i_ready, 0);
        step();
        d_strobe = 0; m_ready = 0;
        step();
        // simultaneous requests right after reset alternate D, I, D
        clrn = 0; step(); clrn = 1;
        i_strobe = 1; d_strobe = 1; m_ready = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("alt_grant", grant, seq[k]);
        end
        i_strobe = 0; d_strobe = 0; m_ready = 0;
        while (owner != 0) begin m_ready = 1; step(); end
        m_ready = 0;
        // write fields must hold after the requester changes them
        d_strobe = 1; d_rw = 1; d_wen = 4'b0011; d_size = 2'b01; d_dout = 32'h1234_5678;
        step();
        d_dout = 0; d_wen = 0; d_size = 0; d_rw = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("wr_m_din", m_din, 32'h1234_5678);
            check("wr_m_wen", m_wen, 4'b0011);
            check("wr_m_size", m_size, 2'b01);
            check("wr_m_rw", m_rw, 1);
        end
        d_strobe = 0; m_ready = 1; step();
        // spurious ready while idle
        for (int k = 0; k < 3; k++) step();
        check("spur_grant", grant, 0);
        m_ready = 0;
        // reset mid instruction transaction, then contention goes to D
        i_strobe = 1; step();
        check("rst_pre_grant", grant, 2'b01);
        clrn = 0; m_ready = 1; step();
        check("rst_m_strobe", m_strobe, 0);
        clrn = 1; m_ready = 0; d_strobe = 1; step();
        check("rst_post_grant", grant, 2'b10);
        i_strobe = 0; d_strobe = 0; m_ready = 1; step(); m_ready = 0; step();
        // instruction strobe withdrawn mid-transaction still completes
        i_strobe = 1; i_a = 32'h0000_0400; step();
        i_strobe = 0; step(); step();
        check("wd_m_strobe", m_strobe, 1);
        m_ready = 1; step();
        m_ready = 0; step();
        check("wd_grant", grant, 0);
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            i_a = $urandom; i_dout = $urandom; i_wen = 4'($urandom); i_size = 2'($urandom); i_rw = 1'($urandom);
            d_a = $urandom; d_dout = $urandom; d_wen = 4'($urandom); d_size = 2'($urandom); d_rw = 1'($urandom);
            i_strobe = $urandom_range(0, 2) != 0;
            d_strobe = $urandom_range(0, 2) != 0;
            m_ready = $urandom_range(0, 2) == 0;
            m_dout = $urandom;
            clrn = $urandom_range(0, 149) != 0;
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
